// File: rtl/mar_burst.sv
// Memory address register with single-step increment, programmable wrap limit
// and a req/ack burst sequencer that walks the address through N locations.

// Next-address generator: shared by the single-step and burst paths.
module mar_nxt #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] limit,
  input  logic          wrap_en,
  output logic [AW-1:0] nxt,
  output logic          wrap
);
  logic hit;

  assign hit  = (a == limit);
  assign nxt  = (hit && wrap_en) ? '0 : a + AW'(1);
  // A zero result counts as a wrap unless it came from 0 with 0 not being the limit
  assign wrap = (nxt == '0) && ((a != '0) || hit);
endmodule

module mar_burst #(
  parameter int AW  = 8,
  parameter int BLW = 4
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic [AW-1:0]  busin,
  input  logic           wa,
  input  logic           wl,
  input  logic           inc,
  input  logic           wrap_en,
  input  logic           burst_start,
  input  logic [BLW-1:0] burst_len,
  input  logic           mem_ack,
  output logic [AW-1:0]  addrout,
  output logic           mem_req,
  output logic           busy,
  output logic           burst_done,
  output logic           wrapped
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t         state;
  logic [AW-1:0]  addr;
  logic [AW-1:0]  limit;
  logic [BLW-1:0] count;
  logic [AW-1:0]  nxt;
  logic           wrap;

  mar_nxt #(.AW(AW)) u_nxt (
    .a       (addr),
    .limit   (limit),
    .wrap_en (wrap_en),
    .nxt     (nxt),
    .wrap    (wrap)
  );

  assign addrout = addr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      addr       <= '0;
      limit      <= '1;
      count      <= '0;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      wrapped    <= 1'b0;
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          // Limit load is independent; a same-cycle inc still sees the old limit
          if (wl) limit <= busin;
          if (wa) begin
            addr <= busin;
          end else if (inc) begin
            addr    <= nxt;
            wrapped <= wrap;
          end else if (burst_start && (burst_len != '0)) begin
            count   <= burst_len;
            state   <= BURST;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        BURST: begin
          if (mem_ack) begin
            addr    <= nxt;
            wrapped <= wrap;
            count   <= count - BLW'(1);
            if (count == BLW'(1)) begin
              state      <= DONE;
              mem_req    <= 1'b0;
              burst_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mar_burst.sv
// Directed bench for mar_burst: load/step, wrap limit, roll-over, bursts and reset.
module tb_mar_burst;
  localparam int AW  = 8;
  localparam int BLW = 4;

  logic           clk = 1'b0;
  logic           clr_n;
  logic [AW-1:0]  busin;
  logic           wa, wl, inc, wrap_en, burst_start, mem_ack;
  logic [BLW-1:0] burst_len;
  logic [AW-1:0]  addrout;
  logic           mem_req, busy, burst_done, wrapped;

  int checks = 0;
  int errors = 0;

  mar_burst #(.AW(AW), .BLW(BLW)) dut (
    .clk(clk), .clr_n(clr_n), .busin(busin), .wa(wa), .wl(wl), .inc(inc),
    .wrap_en(wrap_en), .burst_start(burst_start), .burst_len(burst_len),
    .mem_ack(mem_ack), .addrout(addrout), .mem_req(mem_req), .busy(busy),
    .burst_done(burst_done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wa = 0; wl = 0; inc = 0; burst_start = 0; mem_ack = 0; busin = '0; burst_len = '0;
  endtask

  task automatic load(input logic [AW-1:0] v);
    quiet(); wa = 1; busin = v; tick(); wa = 0;
  endtask

  task automatic set_limit(input logic [AW-1:0] v);
    quiet(); wl = 1; busin = v; tick(); wl = 0;
  endtask

  task automatic test_reset();
    quiet(); wrap_en = 0; clr_n = 0;
    #12;
    checks++; if (addrout !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h exp 00", addrout); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (burst_done !== 1'b0 || wrapped !== 1'b0) begin errors++; $display("FAIL reset_pulses: done=%b wrapped=%b exp 0 0", burst_done, wrapped); end
    @(negedge clk); clr_n = 1;
    tick();
  endtask

  task automatic test_load_step();
    load(8'h3C);
    checks++; if (addrout !== 8'h3C) begin errors++; $display("FAIL load: got %h exp 3C", addrout); end
    inc = 1;
    tick(); checks++; if (addrout !== 8'h3D) begin errors++; $display("FAIL inc1: got %h exp 3D", addrout); end
    tick(); checks++; if (addrout !== 8'h3E) begin errors++; $display("FAIL inc2: got %h exp 3E", addrout); end
    tick(); checks++; if (addrout !== 8'h3F) begin errors++; $display("FAIL inc3: got %h exp 3F", addrout); end
    wa = 1; busin = 8'h10; tick(); quiet();
    checks++; if (addrout !== 8'h10) begin errors++; $display("FAIL wa_over_inc: got %h exp 10", addrout); end
  endtask

  task automatic test_wrap_limit();
    wrap_en = 1;
    set_limit(8'h05);
    load(8'h04);
    inc = 1; tick();
    checks++; if (addrout !== 8'h05 || wrapped !== 1'b0) begin errors++; $display("FAIL lim_step: got %h/%b exp 05/0", addrout, wrapped); end
    tick(); inc = 0;
    checks++; if (addrout !== 8'h00) begin errors++; $display("FAIL lim_wrap: got %h exp 00", addrout); end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL lim_wrapped: got %b exp 1", wrapped); end
    tick();
    checks++; if (wrapped !== 1'b0 || addrout !== 8'h00) begin errors++; $display("FAIL lim_pulse_end: got %h/%b exp 00/0", addrout, wrapped); end
    wrap_en = 0;
    load(8'h04);
    inc = 1; tick(); tick(); inc = 0;
    checks++; if (addrout !== 8'h06 || wrapped !== 1'b0) begin errors++; $display("FAIL lim_nowrap: got %h/%b exp 06/0", addrout, wrapped); end
    // wl and inc together: inc sees the old limit 05, new limit becomes 04
    wrap_en = 1;
    load(8'h04);
    wl = 1; inc = 1; busin = 8'h04; tick(); quiet();
    checks++; if (addrout !== 8'h05) begin errors++; $display("FAIL wl_inc_old: got %h exp 05", addrout); end
    load(8'h04);
    inc = 1; tick(); inc = 0;
    checks++; if (addrout !== 8'h00 || wrapped !== 1'b1) begin errors++; $display("FAIL wl_new: got %h/%b exp 00/1", addrout, wrapped); end
    set_limit(8'hFF);
    wrap_en = 0;
  endtask

  task automatic test_rollover();
    wrap_en = 0;
    load(8'hFF);
    inc = 1; tick(); inc = 0;
    checks++; if (addrout !== 8'h00 || wrapped !== 1'b1) begin errors++; $display("FAIL rollover: got %h/%b exp 00/1", addrout, wrapped); end
  endtask

  task automatic test_burst_stall();
    logic       acks [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp  [4] = '{8'h21, 8'h21, 8'h22, 8'h23};
    int req_cycles = 0;
    int done_cnt = 0;
    load(8'h20);
    burst_start = 1; burst_len = 4'd3; tick(); quiet();
    checks++; if (addrout !== 8'h20 || busy !== 1'b1) begin errors++; $display("FAIL bs_start: got %h/%b exp 20/1", addrout, busy); end
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      if (burst_done === 1'b1) done_cnt++;
      mem_ack = acks[i]; tick();
      checks++; if (addrout !== exp[i]) begin errors++; $display("FAIL bs_addr%0d: got %h exp %h", i, addrout, exp[i]); end
    end
    mem_ack = 0;
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL bs_req_cycles: got %0d exp 4", req_cycles); end
    checks++; if (mem_req !== 1'b0 || burst_done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bs_done: req=%b done=%b busy=%b exp 0 1 1", mem_req, burst_done, busy); end
    if (burst_done === 1'b1) done_cnt++;
    tick();
    if (burst_done === 1'b1) done_cnt++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bs_busy_drop: got %b exp 0", busy); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bs_done_once: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_burst_edge();
    load(8'h40);
    burst_start = 1; burst_len = 4'd0; tick(); quiet();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || addrout !== 8'h40) begin errors++; $display("FAIL len0: busy=%b req=%b addr=%h exp 0 0 40", busy, mem_req, addrout); end
    burst_start = 1; burst_len = 4'd2; tick(); quiet();
    wa = 1; inc = 1; wl = 1; busin = 8'h77; mem_ack = 1;
    tick();
    checks++; if (addrout !== 8'h41) begin errors++; $display("FAIL ign_addr1: got %h exp 41", addrout); end
    tick(); quiet();
    checks++; if (addrout !== 8'h42 || burst_done !== 1'b1) begin errors++; $display("FAIL ign_addr2: got %h/%b exp 42/1", addrout, burst_done); end
    tick();
    // limit must still be FF: with wrap enabled, 77 steps to 78
    wrap_en = 1;
    load(8'h77);
    inc = 1; tick(); inc = 0;
    checks++; if (addrout !== 8'h78) begin errors++; $display("FAIL ign_wl: got %h exp 78", addrout); end
    wrap_en = 0;
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp [3] = '{8'h21, 8'h00, 8'h01};
    logic       wexp[3] = '{1'b0, 1'b1, 1'b0};
    wrap_en = 1;
    set_limit(8'h21);
    load(8'h20);
    burst_start = 1; burst_len = 4'd3; tick(); quiet();
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (addrout !== exp[i] || wrapped !== wexp[i]) begin errors++; $display("FAIL bw_step%0d: got %h/%b exp %h/%b", i, addrout, wrapped, exp[i], wexp[i]); end
    end
    mem_ack = 0;
    checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL bw_done: got %b exp 1", burst_done); end
    tick();
    set_limit(8'hFF);
    wrap_en = 0;
  endtask

  task automatic test_back_to_back();
    load(8'h50);
    burst_start = 1; burst_len = 4'd1; tick(); quiet();
    mem_ack = 1; tick(); mem_ack = 0;
    checks++; if (addrout !== 8'h51 || burst_done !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b exp 51/1", addrout, burst_done); end
    burst_start = 1; burst_len = 4'd2; tick();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore: busy=%b req=%b exp 0 0", busy, mem_req); end
    tick(); quiet();
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_second: req=%b busy=%b exp 1 1", mem_req, busy); end
    mem_ack = 1; tick(); tick(); mem_ack = 0;
    checks++; if (addrout !== 8'h53 || burst_done !== 1'b1) begin errors++; $display("FAIL b2b_end: got %h/%b exp 53/1", addrout, burst_done); end
    tick();
  endtask

  task automatic test_reset_midburst();
    set_limit(8'h31);
    load(8'h30);
    burst_start = 1; burst_len = 4'd5; tick(); quiet();
    mem_ack = 1; tick(); mem_ack = 0;
    checks++; if (addrout !== 8'h31 || mem_req !== 1'b1) begin errors++; $display("FAIL rm_pre: got %h/%b exp 31/1", addrout, mem_req); end
    #3 clr_n = 0;
    #1;
    checks++; if (addrout !== 8'h00 || mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async: addr=%h req=%b busy=%b exp 00 0 0", addrout, mem_req, busy); end
    #2 clr_n = 1;
    tick();
    checks++; if (burst_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_no_done: done=%b busy=%b exp 0 0", burst_done, busy); end
    // limit back to FF: 31 steps to 32 even with wrap enabled
    wrap_en = 1;
    load(8'h31);
    inc = 1; tick(); inc = 0;
    checks++; if (addrout !== 8'h32) begin errors++; $display("FAIL rm_limit: got %h exp 32", addrout); end
    wrap_en = 0;
    load(8'hFF);
    inc = 1; tick(); inc = 0;
    checks++; if (addrout !== 8'h00 || wrapped !== 1'b1) begin errors++; $display("FAIL rm_wrap: got %h/%b exp 00/1", addrout, wrapped); end
  endtask

  initial begin
    test_reset();
    test_load_step();
    test_wrap_limit();
    test_rollover();
    test_burst_stall();
    test_burst_edge();
    test_burst_wrap();
    test_back_to_back();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
